// File: rtl/ir_mark_space_engine.sv
// rtl/ir_mark_space_engine.sv - FIFO-fed IR mark/space transmit engine with programmable carrier
// Entries (mark, space, last) are replayed as carrier-modulated marks and silent spaces on NCH outputs.
module ir_mark_space_engine #(
   parameter int DIV_W = 16,
   parameter int DUR_W = 16,
   parameter int DEPTH = 8,
   parameter int NCH   = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DIV_W-1:0]             carrier_per,
   input  logic [DIV_W-1:0]             carrier_hi,
   input  logic [NCH-1:0]               ch_mask,
   input  logic                         push_valid,
   output logic                         push_ready,
   input  logic [DUR_W-1:0]             push_mark,
   input  logic [DUR_W-1:0]             push_space,
   input  logic                         push_last,
   input  logic                         start,
   input  logic                         abort,
   output logic                         busy,
   output logic                         done,
   output logic                         underrun,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
   output logic [NCH-1:0]               ir_out
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH+1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_MARK  = 2'd2;
   localparam logic [1:0] S_SPACE = 2'd3;

   logic [DUR_W-1:0] mem_mark  [DEPTH];
   logic [DUR_W-1:0] mem_space [DEPTH];
   logic             mem_last  [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    level, level_next;
   logic             push_fire, pop_fire;

   logic [1:0]       state, state_d;
   logic [DIV_W-1:0] cnt, per_q, hi_q;
   logic [NCH-1:0]   mask_q;
   logic [DUR_W-1:0] mark_rem, space_rem;
   logic             last_q;
   logic             done_d, und_d, entry_end, end_last, wrap;
   logic [DIV_W-1:0] per_clamped;

   assign push_ready = (level != LW'(DEPTH)) && !abort;
   assign push_fire  = push_valid && push_ready;
   assign pop_fire   = (state == S_LOAD);
   assign level_next = level + LW'(push_fire) - LW'(pop_fire);
   assign fifo_level = level;
   assign busy       = (state != S_IDLE);
   assign wrap       = (cnt == per_q - DIV_W'(1));
   assign per_clamped = (carrier_per < DIV_W'(2)) ? DIV_W'(2) : carrier_per;

   always_comb begin
      state_d   = state;
      done_d    = 1'b0;
      und_d     = 1'b0;
      entry_end = 1'b0;
      end_last  = last_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (level != '0) state_d = S_LOAD;
               else             und_d   = 1'b1;
            end
         end
         S_LOAD: begin
            if (mem_mark[rd_ptr] != '0)       state_d = S_MARK;
            else if (mem_space[rd_ptr] != '0) state_d = S_SPACE;
            else begin
               entry_end = 1'b1;
               end_last  = mem_last[rd_ptr];
            end
         end
         S_MARK: begin
            if (wrap && mark_rem == DUR_W'(1)) begin
               if (space_rem != '0) state_d = S_SPACE;
               else                 entry_end = 1'b1;
            end
         end
         default: begin
            if (wrap && space_rem == DUR_W'(1)) entry_end = 1'b1;
         end
      endcase
      // The FIFO check sees this cycle's pop and push so a refill landing now avoids underrun.
      if (entry_end) begin
         if (end_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end else if (level_next != '0) begin
            state_d = S_LOAD;
         end else begin
            state_d = S_IDLE;
            und_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_fire) begin
         mem_mark[wr_ptr]  <= push_mark;
         mem_space[wr_ptr] <= push_space;
         mem_last[wr_ptr]  <= push_last;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         done      <= 1'b0;
         underrun  <= 1'b0;
         ir_out    <= '0;
         if (!rst_n) begin
            cnt       <= '0;
            per_q     <= '0;
            hi_q      <= '0;
            mask_q    <= '0;
            mark_rem  <= '0;
            space_rem <= '0;
            last_q    <= 1'b0;
         end
      end else begin
         state    <= state_d;
         done     <= done_d;
         underrun <= und_d;
         level    <= level_next;
         if (push_fire) wr_ptr <= wr_ptr + AW'(1);
         if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
         ir_out <= (state == S_MARK && cnt < hi_q) ? mask_q : '0;
         case (state)
            S_LOAD: begin
               per_q     <= per_clamped;
               hi_q      <= carrier_hi;
               mask_q    <= ch_mask;
               cnt       <= '0;
               mark_rem  <= mem_mark[rd_ptr];
               space_rem <= mem_space[rd_ptr];
               last_q    <= mem_last[rd_ptr];
            end
            S_MARK: begin
               if (wrap) begin
                  cnt      <= '0;
                  mark_rem <= mark_rem - DUR_W'(1);
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            S_SPACE: begin
               if (wrap) begin
                  cnt       <= '0;
                  space_rem <= space_rem - DUR_W'(1);
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ir_mark_space_engine.sv
// tb/tb_ir_mark_space_engine.sv - scoreboard bench for ir_mark_space_engine
// Expected per-clock output traces are queued when a burst is started and popped each negedge.
module tb_ir_mark_space_engine;

   localparam int DIV_W = 16;
   localparam int DUR_W = 16;
   localparam int DEPTH = 8;
   localparam int NCH   = 4;
   localparam int LW    = $clog2(DEPTH+1);

   logic             clk;
   logic             rst_n;
   logic [DIV_W-1:0] carrier_per, carrier_hi;
   logic [NCH-1:0]   ch_mask;
   logic             push_valid, push_ready;
   logic [DUR_W-1:0] push_mark, push_space;
   logic             push_last, start, abort;
   logic             busy, done, underrun;
   logic [LW-1:0]    fifo_level;
   logic [NCH-1:0]   ir_out;

   ir_mark_space_engine #(.DIV_W(DIV_W), .DUR_W(DUR_W), .DEPTH(DEPTH), .NCH(NCH)) dut (
      .clk(clk), .rst_n(rst_n), .carrier_per(carrier_per), .carrier_hi(carrier_hi),
      .ch_mask(ch_mask), .push_valid(push_valid), .push_ready(push_ready),
      .push_mark(push_mark), .push_space(push_space), .push_last(push_last),
      .start(start), .abort(abort), .busy(busy), .done(done), .underrun(underrun),
      .fifo_level(fifo_level), .ir_out(ir_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH-1:0] ir;
      logic           done;
      logic           und;
      logic           busy;
   } exp_t;

   logic [NCH-1:0] cyc_q[$];
   exp_t           sb[$];
   int vectors = 0;
   int errors  = 0;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // State-cycle trace: element k is what ir_out shows k edges after the start edge.
   task automatic model_start();
      cyc_q.delete();
      cyc_q.push_back('0);
   endtask

   task automatic model_entry(input int m, input int s, input int per, input int hi,
                              input logic [NCH-1:0] mask);
      int p;
      p = (per < 2) ? 2 : per;
      cyc_q.push_back('0);
      for (int i = 0; i < m*p; i++) cyc_q.push_back(((i % p) < hi) ? mask : '0);
      for (int i = 0; i < s*p; i++) cyc_q.push_back('0);
   endtask

   task automatic model_end(input bit is_done);
      int n;
      exp_t e;
      n = cyc_q.size();
      for (int j = 0; j < n; j++) begin
         e.ir   = cyc_q[j];
         e.done = is_done && (j == n-1);
         e.und  = !is_done && (j == n-1);
         e.busy = (j != n-1);
         sb.push_back(e);
      end
      e = '0;
      sb.push_back(e);
   endtask

   task automatic check_sb(input string name, input int chg_at, input logic [NCH-1:0] chg_val);
      int j;
      exp_t e;
      logic [NCH+2:0] got, want;
      j = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         if (j == chg_at) ch_mask = chg_val;
         e = sb.pop_front();
         got  = {ir_out, done, underrun, busy};
         want = {e.ir, e.done, e.und, e.busy};
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL %s sample %0d: got ir=%b done=%b und=%b busy=%b, want ir=%b done=%b und=%b busy=%b",
                     name, j, ir_out, done, underrun, busy, e.ir, e.done, e.und, e.busy);
         end
         j++;
      end
   endtask

   task automatic push_entry(input int m, input int s, input bit l);
      @(negedge clk);
      push_valid = 1'b1;
      push_mark  = DUR_W'(m);
      push_space = DUR_W'(s);
      push_last  = l;
      @(posedge clk);
      #1 push_valid = 1'b0;
   endtask

   task automatic start_burst();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic set_carrier(input int per, input int hi, input logic [NCH-1:0] mask);
      carrier_per = DIV_W'(per);
      carrier_hi  = DIV_W'(hi);
      ch_mask     = mask;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; carrier_per = '0; carrier_hi = '0; ch_mask = '0;
      push_valid = 1'b0; push_mark = '0; push_space = '0; push_last = 1'b0;
      start = 1'b0; abort = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({ir_out, busy, done, underrun, push_ready} !== {{NCH{1'b0}}, 4'b0001} || fifo_level !== '0) begin
         errors++;
         $display("FAIL reset: got ir=%b busy=%b done=%b und=%b ready=%b level=%0d, want 0,0,0,0,1,0",
                  ir_out, busy, done, underrun, push_ready, fifo_level);
      end
   endtask

   task automatic test_basic();
      set_carrier(4, 2, 4'b0001);
      push_entry(3, 2, 1);
      model_start(); model_entry(3, 2, 4, 2, 4'b0001); model_end(1);
      start_burst();
      check_sb("basic", -1, '0);
   endtask

   task automatic test_multi_zero();
      set_carrier(6, 3, 4'b0001);
      push_entry(2, 0, 0);
      push_entry(0, 3, 0);
      push_entry(1, 1, 1);
      model_start();
      model_entry(2, 0, 6, 3, 4'b0001);
      model_entry(0, 3, 6, 3, 4'b0001);
      model_entry(1, 1, 6, 3, 4'b0001);
      model_end(1);
      start_burst();
      check_sb("multi_zero", -1, '0);
   endtask

   task automatic test_underrun();
      set_carrier(4, 2, 4'b0010);
      push_entry(2, 2, 0);
      model_start(); model_entry(2, 2, 4, 2, 4'b0010); model_end(0);
      start_burst();
      check_sb("underrun", -1, '0);
      vectors++;
      if (fifo_level !== '0) begin
         errors++;
         $display("FAIL underrun_level: got %0d want 0", fifo_level);
      end
   endtask

   task automatic test_fifo_full_wrap();
      int mk[12];
      int sp[12];
      set_carrier(2, 1, 4'b0101);
      for (int i = 0; i < 12; i++) begin
         mk[i] = i % 4 + 1;
         sp[i] = (i * 3) % 4;
      end
      for (int i = 0; i < 8; i++) push_entry(mk[i], sp[i], 1'b0);
      @(negedge clk);
      vectors++;
      if (fifo_level !== LW'(DEPTH) || push_ready !== 1'b0) begin
         errors++;
         $display("FAIL fifo_full: got level=%0d ready=%b want level=%0d ready=0", fifo_level, push_ready, DEPTH);
      end
      push_entry(9, 9, 1);
      @(negedge clk);
      vectors++;
      if (fifo_level !== LW'(DEPTH)) begin
         errors++;
         $display("FAIL fifo_extra_push: got level=%0d want %0d", fifo_level, DEPTH);
      end
      model_start();
      for (int i = 0; i < 12; i++) model_entry(mk[i], sp[i], 2, 1, 4'b0101);
      model_end(1);
      start_burst();
      fork
         check_sb("fifo_wrap", -1, '0);
         begin
            for (int k = 8; k < 12; k++) begin
               int w;
               w = 0;
               @(negedge clk);
               while (!push_ready && w < 200) begin
                  @(negedge clk);
                  w++;
               end
               if (!push_ready) begin
                  vectors++;
                  errors++;
                  $display("FAIL refill_timeout: got ready=%b want 1 within 200 clocks", push_ready);
               end else begin
                  push_valid = 1'b1;
                  push_mark  = DUR_W'(mk[k]);
                  push_space = DUR_W'(sp[k]);
                  push_last  = (k == 11);
                  @(posedge clk);
                  #1 push_valid = 1'b0;
               end
            end
         end
      join
      vectors++;
      if (fifo_level !== '0) begin
         errors++;
         $display("FAIL fifo_drained: got level=%0d want 0", fifo_level);
      end
   endtask

   task automatic test_abort();
      set_carrier(4, 2, 4'b0001);
      push_entry(100, 0, 1);
      push_entry(2, 2, 1);
      model_start(); model_entry(100, 0, 4, 2, 4'b0001); model_end(1);
      while (sb.size() > 12) void'(sb.pop_back());
      start_burst();
      check_sb("abort_pre", -1, '0);
      abort = 1'b1;
      push_valid = 1'b1; push_mark = DUR_W'(5); push_space = DUR_W'(5); push_last = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0; push_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({ir_out, busy, done, underrun} !== {{NCH{1'b0}}, 3'b000} || fifo_level !== '0) begin
         errors++;
         $display("FAIL abort_state: got ir=%b busy=%b done=%b und=%b level=%0d want all 0",
                  ir_out, busy, done, underrun, fifo_level);
      end
      @(negedge clk);
      vectors++;
      if (ir_out !== '0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_after: got ir=%b done=%b want 0 0", ir_out, done);
      end
      start_burst();
      @(negedge clk);
      vectors++;
      if (underrun !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_restart: got und=%b busy=%b want 1 0", underrun, busy);
      end
      @(negedge clk);
      vectors++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL abort_und_pulse: got und=%b want 0", underrun);
      end
   endtask

   task automatic test_carrier_edges();
      set_carrier(1, 5, 4'b1111);
      push_entry(3, 1, 1);
      model_start(); model_entry(3, 1, 1, 5, 4'b1111); model_end(1);
      start_burst();
      check_sb("per_clamp_hi", -1, '0);

      set_carrier(4, 0, 4'b1111);
      push_entry(2, 1, 1);
      model_start(); model_entry(2, 1, 4, 0, 4'b1111); model_end(1);
      start_burst();
      check_sb("hi_zero", -1, '0);

      set_carrier(4, 2, 4'b0011);
      push_entry(2, 1, 0);
      push_entry(2, 1, 1);
      model_start();
      model_entry(2, 1, 4, 2, 4'b0011);
      model_entry(2, 1, 4, 2, 4'b1100);
      model_end(1);
      start_burst();
      check_sb("mask_change", 3, 4'b1100);
   endtask

   task automatic test_reset_mid();
      set_carrier(4, 4, 4'b1000);
      push_entry(5, 1, 0);
      push_entry(5, 1, 1);
      start_burst();
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if ({ir_out, busy, done, underrun, push_ready} !== {{NCH{1'b0}}, 4'b0001} || fifo_level !== '0) begin
         errors++;
         $display("FAIL reset_mid: got ir=%b busy=%b done=%b und=%b ready=%b level=%0d want 0,0,0,0,1,0",
                  ir_out, busy, done, underrun, push_ready, fifo_level);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multi_zero();
      test_underrun();
      test_fifo_full_wrap();
      test_abort();
      test_carrier_edges();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/ir_mark_space_engine.md
Name: ir_mark_space_engine

Overview:
Parametrised IR transmit engine for the TV-B-Gone core. It succeeds the fixed single-output code player. Firmware or the code-table walker pushes (mark, space, last) entries into an internal FIFO. The engine replays them as carrier-modulated marks and silent spaces on up to NCH IR outputs. Carrier period, duty and channel mask are programmable per burst.

Parameters:
DIV_W, 16, width of carrier period/high-time counters (clk cycles)
DUR_W, 16, width of mark/space durations (in carrier periods)
DEPTH, 8, FIFO entries; power of two, >=2
NCH, 4, number of IR output channels

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
carrier_per  in  DIV_W  carrier period in clk cycles; sampled at LOAD
carrier_hi  in  DIV_W  carrier high time in clk cycles; sampled at LOAD
ch_mask  in  NCH  enabled output channels; sampled at LOAD
push_valid  in  1  FIFO write request
push_ready  out  1  FIFO can accept entry
push_mark  in  DUR_W  mark length, carrier periods
push_space  in  DUR_W  space length, carrier periods
push_last  in  1  entry terminates the burst
start  in  1  begin playback (ignored unless IDLE)
abort  in  1  stop playback and flush FIFO
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: burst finished on a last entry
underrun  out  1  one-cycle pulse: FIFO empty before last entry
fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy
ir_out  out  NCH  modulated IR outputs (registered)

Behaviour:
- Reset (rst_n low at clk edge) values: state IDLE, FIFO empty, fifo_level 0, push_ready 1, busy/done/underrun 0, ir_out 0, all counters 0.
- FIFO:
  - Write occurs when push_valid && push_ready.
  - push_ready = !full && !abort; it is not pop-aware, so a full FIFO refuses even when a pop occurs in the same cycle.
  - A push and pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
- States are IDLE, LOAD, MARK, SPACE.
- IDLE:
  - start=1 with FIFO non-empty -> LOAD.
  - start=1 with FIFO empty -> underrun pulse, stay IDLE.
- LOAD:
  - Pops one entry.
  - Latches carrier_per (values <2 are clamped to 2), carrier_hi and ch_mask.
  - Clears the carrier counter.
  - Next state: MARK if mark != 0, else SPACE if space != 0, else end-of-entry.
- MARK:
  - Carrier counter cnt runs 0..per-1 and wraps.
  - Modulation bit = (cnt < hi); hi >= per gives constant high, hi = 0 gives constant low.
  - On wrap, mark_rem decrements. When it reaches 0 at a wrap, go to SPACE if space != 0, else end-of-entry.
  - Mark lasts exactly mark*per clocks.
- SPACE:
  - Modulation bit is 0. The same counter runs, and space lasts exactly space*per clocks.
  - Then end-of-entry.
- End-of-entry:
  - If last=1 -> done pulse, IDLE.
  - Else if FIFO non-empty -> LOAD (adds one gap clock, low).
  - Else -> underrun pulse, IDLE.
- ir_out[i] <= modulation bit & latched ch_mask[i]; it is registered, one clock after state/counter.
- Latency: the edge sampling start enters LOAD; the next edge enters MARK with cnt=0; ir_out first goes high on the following edge, i.e. 2 edges after start is sampled.
- abort:
  - Has priority over everything. At the sampling edge: state IDLE, FIFO flushed, ir_out 0 on the following edge, no done/underrun pulse.
  - A push in the same cycle is dropped.
- start while busy is ignored.
- carrier_per/hi/ch_mask changes while busy take effect only at the next LOAD.
- Reset mid-burst behaves like abort plus clearing all outputs at the same edge.

Test Plan:
1. Basic burst: per=4, hi=2, mask=0001; push (mark=3, space=2, last=1); start -> ir_out[0]=1100 repeated 3 times, then 8 clocks low, done pulse once; ir_out[3:1] stay 0; busy drops with done.
2. Multi-entry and zero lengths: push (2,0,0), (0,3,0), (1,1,1), per=6, hi=3 -> 12 clk modulated, gap, 18 clk low, gap, 6 clk modulated, 6 low, single done; underrun never asserts.
3. Underrun: push (2,2,0) only, start -> mark/space play, then underrun pulse, ir_out 0, IDLE; fifo_level 0.
4. FIFO full/wrap: push DEPTH entries -> push_ready=0, fifo_level=DEPTH; extra push is not accepted. Start, refill while draining across pointer wrap -> playback order exactly matches push order.
5. Abort mid-mark: per=4, mark=100, abort at clock 10 of the mark -> ir_out 0 next edge, fifo_level 0, no done; a new start with an empty FIFO gives underrun.
6. Carrier edge cases: per=1 (clamped to 2), hi=5 -> constant-high mark on mask=1111 for 2*mark clocks; hi=0 -> all outputs low during the mark; a ch_mask change mid-burst is applied only at the next entry.
